// File: rtl/alu_seq.sv
// alu_seq: registered ALU with one operation per start pulse.
// Add, sub, compare, parity and illegal ops finish in one edge.
// Multiply is an unsigned shift-add that runs WIDTH iterations in state MUL.
// done pulses for one cycle when out/compres/carry are updated.
// The outputs hold their values between done pulses.
module alu_seq #(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cmp_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             compres,
    output logic             carry
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_CMP = 4'b0100;
    localparam logic [3:0] OP_PAR = 4'b0101;
    localparam int         CW     = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             compres_q, compres_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mlr_q, mlr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;
    logic             b_lt_a;
    logic             b_eq_a;
    logic             cmp_hit;

    // Wide add/sub keep the carry and borrow in the extra top bit.
    // The multiply step adds the multiplicand only when the multiplier LSB is set.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign partial = mlr_q[0] ? mcand_q : '0;
    assign acc_sum = acc_q + partial;
    assign b_eq_a  = (b == a);

    // Signedness of the ordering compare is fixed at elaboration.
    generate
        if (SIGNED_CMP) begin : g_signed_cmp
            assign b_lt_a = ($signed(b) < $signed(a));
        end else begin : g_unsigned_cmp
            assign b_lt_a = (b < a);
        end
    endgenerate

    // Six-way compare of b relative to a; selects 6 and 7 are always false.
    always_comb begin
        cmp_hit = 1'b0;
        case (cmp_sel)
            3'd0:    cmp_hit = b_eq_a;
            3'd1:    cmp_hit = b_lt_a | b_eq_a;
            3'd2:    cmp_hit = ~b_lt_a;
            3'd3:    cmp_hit = ~b_eq_a;
            3'd4:    cmp_hit = b_lt_a;
            3'd5:    cmp_hit = ~b_lt_a & ~b_eq_a;
            default: cmp_hit = 1'b0;
        endcase
    end

    // Next-state and result logic; outputs hold unless a result is produced.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        out_d     = out_q;
        compres_d = compres_q;
        carry_d   = carry_q;
        mcand_d   = mcand_q;
        mlr_d     = mlr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d = a;
                        mlr_d   = b;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = MUL;
                    end else begin
                        done_d    = 1'b1;
                        out_d     = '0;
                        compres_d = 1'b0;
                        carry_d   = 1'b0;
                        case (op)
                            OP_ADD: begin
                                out_d   = sum[WIDTH-1:0];
                                carry_d = sum[WIDTH];
                            end
                            OP_SUB: begin
                                out_d   = diff[WIDTH-1:0];
                                carry_d = diff[WIDTH];
                            end
                            OP_CMP:  compres_d = cmp_hit;
                            OP_PAR:  out_d = {{(WIDTH-1){1'b0}}, ^a};
                            default: ;
                        endcase
                    end
                end
            end
            MUL: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mlr_d   = mlr_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d     = acc_sum;
                    compres_d = 1'b0;
                    carry_d   = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            out_q     <= '0;
            compres_q <= 1'b0;
            carry_q   <= 1'b0;
            mcand_q   <= '0;
            mlr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            out_q     <= out_d;
            compres_q <= compres_d;
            carry_q   <= carry_d;
            mcand_q   <= mcand_d;
            mlr_q     <= mlr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy    = (state_q == MUL);
    assign done    = done_q;
    assign out     = out_q;
    assign compres = compres_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq.
// Two instances share the inputs: dut uses unsigned compares and dut_s uses signed compares.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [2:0]  cmp_sel;
    logic        busy, done, compres, carry;
    logic [15:0] out;
    logic        busy_s, done_s, compres_s, carry_s;
    logic [15:0] out_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut (
        .clock(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cmp_sel(cmp_sel), .busy(busy), .done(done), .out(out),
        .compres(compres), .carry(carry)
    );

    alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b1)) dut_s (
        .clock(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cmp_sel(cmp_sel), .busy(busy_s), .done(done_s), .out(out_s),
        .compres(compres_s), .carry(carry_s)
    );

    // Count one comparison and report it if it does not match.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Present one request for one edge, then return 1 time unit after that edge.
    task automatic do_op(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                         input logic [2:0] cs);
        start = 1'b1; op = o; a = xa; b = xb; cmp_sel = cs;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected compres for selects 0..7, with b taken relative to a.
    logic [7:0] exp_eq_pair  = 8'b0000_0111; // a=3,b=3: eq, le, ge
    logic [7:0] exp_gt_pair  = 8'b0010_1100; // a=3,b=9: ge, ne, gt
    int n;
    int busy_cycles;

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; cmp_sel = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_out", {16'd0, out}, 32'd0);
        check_val("rst_compres", {31'd0, compres}, 32'd0);
        check_val("rst_carry", {31'd0, carry}, 32'd0);

        // add with carry out
        do_op(4'b0000, 16'hFFFF, 16'h0002, 3'd0);
        check_val("add_done", {31'd0, done}, 32'd1);
        check_val("add_out", {16'd0, out}, 32'h0001);
        check_val("add_carry", {31'd0, carry}, 32'd1);
        tick();
        check_val("add_done_low", {31'd0, done}, 32'd0);
        check_val("add_out_hold", {16'd0, out}, 32'h0001);

        // add without carry
        do_op(4'b0000, 16'h1234, 16'h0101, 3'd0);
        check_val("add2_out", {16'd0, out}, 32'h1335);
        check_val("add2_carry", {31'd0, carry}, 32'd0);

        // sub with borrow, then without
        do_op(4'b0001, 16'd5, 16'd7, 3'd0);
        check_val("sub_out", {16'd0, out}, 32'hFFFE);
        check_val("sub_carry", {31'd0, carry}, 32'd1);
        do_op(4'b0001, 16'd9, 16'd4, 3'd0);
        check_val("sub2_out", {16'd0, out}, 32'h0005);
        check_val("sub2_carry", {31'd0, carry}, 32'd0);

        // compare sweep, unsigned instance
        for (int s = 0; s < 8; s++) begin
            do_op(4'b0100, 16'd3, 16'd3, 3'(s));
            check_val($sformatf("cmp33_sel%0d", s), {31'd0, compres}, {31'd0, exp_eq_pair[s]});
        end
        for (int s = 0; s < 8; s++) begin
            do_op(4'b0100, 16'd3, 16'd9, 3'(s));
            check_val($sformatf("cmp39_sel%0d", s), {31'd0, compres}, {31'd0, exp_gt_pair[s]});
        end
        check_val("cmp_out_zero", {16'd0, out}, 32'd0);

        // signed versus unsigned lt: b=-1 is below a=1 only when signed
        do_op(4'b0100, 16'h0001, 16'hFFFF, 3'd4);
        check_val("cmp_lt_signed", {31'd0, compres_s}, 32'd1);
        check_val("cmp_lt_unsigned", {31'd0, compres}, 32'd0);

        // compres clears after a non-compare op
        do_op(4'b0000, 16'd1, 16'd1, 3'd0);
        check_val("compres_clear", {31'd0, compres}, 32'd0);

        // back-to-back parity
        do_op(4'b0101, 16'h0007, 16'h0000, 3'd0);
        check_val("par1_done", {31'd0, done}, 32'd1);
        check_val("par1_out", {16'd0, out}, 32'd1);
        do_op(4'b0101, 16'h0003, 16'h0000, 3'd0);
        check_val("par2_done", {31'd0, done}, 32'd1);
        check_val("par2_out", {16'd0, out}, 32'd0);

        // multiply with a start pulsed mid-run
        do_op(4'b0010, 16'h0123, 16'h0011, 3'd0);
        check_val("mul_busy_start", {31'd0, busy}, 32'd1);
        check_val("mul_no_done", {31'd0, done}, 32'd0);
        n = 0; busy_cycles = 0;
        while (!done && n < 40) begin
            if (busy) busy_cycles++;
            if (n == 5) begin
                start = 1'b1; op = 4'b0000; a = 16'h0001; b = 16'h0001;
            end
            tick();
            start = 1'b0;
            n++;
        end
        check_val("mul_latency", n, 32'd16);
        check_val("mul_busy_cycles", busy_cycles, 32'd16);
        check_val("mul_out", {16'd0, out}, 32'h1353);
        check_val("mul_busy_end", {31'd0, busy}, 32'd0);
        check_val("mul_carry", {31'd0, carry}, 32'd0);
        tick();
        check_val("mul_done_low", {31'd0, done}, 32'd0);
        check_val("mul_out_hold", {16'd0, out}, 32'h1353);

        // FFFF x FFFF keeps only the low word
        do_op(4'b0010, 16'hFFFF, 16'hFFFF, 3'd0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check_val("mulff_latency", n, 32'd16);
        check_val("mulff_out", {16'd0, out}, 32'h0001);

        // reset during a multiply aborts it
        do_op(4'b0010, 16'h0123, 16'h0011, 3'd0);
        repeat (4) tick();
        check_val("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_out", {16'd0, out}, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n++;
            tick();
        end
        check_val("abort_no_done", n, 32'd0);

        // illegal op still completes in one edge
        do_op(4'b1111, 16'hABCD, 16'h1234, 3'd0);
        check_val("ill_done", {31'd0, done}, 32'd1);
        check_val("ill_out", {16'd0, out}, 32'd0);
        check_val("ill_carry", {31'd0, carry}, 32'd0);
        check_val("ill_compres", {31'd0, compres}, 32'd0);
        tick();
        check_val("ill_done_low", {31'd0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
